// File: rtl/level_sequencer_if.sv
// Bundle between the game-flow sequencer and its neighbours: block_controller status in,
// display/score outputs back. master = the side that drives the game inputs, slave = the sequencer.
interface level_sequencer_if #(
  parameter int NUM_MONSTERS = 5,
  parameter int NUM_LEVELS   = 2,
  parameter int SCORE_W      = 8
);
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

  logic                    start_pulse;
  logic [NUM_MONSTERS-1:0] monster_destroyed;
  logic                    tank_destroyed;
  logic [SCORE_W-1:0]      score_in;

  logic [LVL_W-1:0]        level;
  logic                    level_load;
  logic                    respawn;
  logic                    playing;
  logic [3:0]              lives_left;
  logic [SCORE_W-1:0]      score;
  logic [6:0]              state;
  logic                    win;
  logic                    lose;

  modport master (
    output start_pulse, monster_destroyed, tank_destroyed, score_in,
    input  level, level_load, respawn, playing, lives_left, score, state, win, lose
  );

  modport slave (
    input  start_pulse, monster_destroyed, tank_destroyed, score_in,
    output level, level_load, respawn, playing, lives_left, score, state, win, lose
  );
endinterface

// File: rtl/level_sequencer.sv
// Game-flow controller: walks through the levels, tracks lives with a timed respawn phase
// and accumulates a saturating game score from the per-level score of block_controller.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | after reset, waiting for the first start pulse
// INTRO    | level intro, timed by the down-counter
// PLAY     | level in progress; score tracks base + score_in
// LVL_DONE | one cycle: advance level or declare the win
// RESPAWN  | tank lost, timed pause before play resumes on the same level
// WIN      | all levels cleared, score frozen until restart
// LOSE     | out of lives, score frozen until restart
module level_sequencer #(
  parameter int                                NUM_MONSTERS   = 5,
  parameter int                                NUM_LEVELS     = 2,
  parameter logic [NUM_LEVELS*NUM_MONSTERS-1:0] CLEAR_MASKS    = {5'b11111, 5'b10101},
  parameter int                                LIVES          = 3,
  parameter int                                INTRO_CYCLES   = 2,
  parameter int                                RESPAWN_CYCLES = 4,
  parameter int                                SCORE_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  level_sequencer_if.slave  bus
);

  localparam int LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int MAX_CYC = (INTRO_CYCLES > RESPAWN_CYCLES) ? INTRO_CYCLES : RESPAWN_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [6:0] S_IDLE     = 7'b0000001;
  localparam logic [6:0] S_INTRO    = 7'b0000010;
  localparam logic [6:0] S_PLAY     = 7'b0000100;
  localparam logic [6:0] S_LVL_DONE = 7'b0001000;
  localparam logic [6:0] S_RESPAWN  = 7'b0010000;
  localparam logic [6:0] S_WIN      = 7'b0100000;
  localparam logic [6:0] S_LOSE     = 7'b1000000;

  // Counter reload values: the counter runs down to zero, so N cycles start from N-1.
  localparam logic [CNT_W-1:0] INTRO_LOAD   = CNT_W'(INTRO_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [LVL_W-1:0] LAST_LEVEL   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [3:0]       LIVES_INIT   = 4'(LIVES);

  logic [6:0]              r_state;
  logic [LVL_W-1:0]        r_level;
  logic [3:0]              r_lives;
  logic [SCORE_W-1:0]      r_score;
  logic [SCORE_W-1:0]      r_base;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_level_load;
  logic                    r_respawn;

  logic [6:0]              w_state_nxt;
  logic [LVL_W-1:0]        w_level_nxt;
  logic [3:0]              w_lives_nxt;
  logic [SCORE_W-1:0]      w_score_nxt;
  logic [SCORE_W-1:0]      w_base_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_level_load_nxt;
  logic                    w_respawn_nxt;

  logic [NUM_MONSTERS-1:0] w_mask;
  logic                    w_clear;
  logic                    w_last_level;
  logic                    w_cnt_done;
  logic [SCORE_W:0]        w_sum;
  logic [SCORE_W-1:0]      w_sum_sat;
  logic [3:0]              w_lives_dec;

  // Select the clear mask of the current level; out-of-range levels never occur.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      if (r_level == LVL_W'(k)) begin
        w_mask = CLEAR_MASKS[k*NUM_MONSTERS +: NUM_MONSTERS];
      end
    end
  end

  assign w_clear      = ((bus.monster_destroyed & w_mask) == w_mask);
  assign w_last_level = (r_level == LAST_LEVEL);
  assign w_cnt_done   = (r_cnt == '0);
  assign w_sum        = {1'b0, r_base} + {1'b0, bus.score_in};
  assign w_sum_sat    = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
  assign w_lives_dec  = r_lives - 4'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; anything that is not a legal one-hot code falls back to IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:     w_state_nxt = bus.start_pulse ? S_INTRO : S_IDLE;
      S_INTRO:    w_state_nxt = w_cnt_done ? S_PLAY : S_INTRO;
      S_PLAY: begin
        if (w_clear) begin
          w_state_nxt = S_LVL_DONE;
        end else if (bus.tank_destroyed) begin
          w_state_nxt = (w_lives_dec == 4'd0) ? S_LOSE : S_RESPAWN;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_LVL_DONE: w_state_nxt = w_last_level ? S_WIN : S_INTRO;
      S_RESPAWN:  w_state_nxt = w_cnt_done ? S_PLAY : S_RESPAWN;
      S_WIN:      w_state_nxt = bus.start_pulse ? S_INTRO : S_WIN;
      S_LOSE:     w_state_nxt = bus.start_pulse ? S_INTRO : S_LOSE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the datapath registers and pulses, decided from the current state.
  always_comb begin
    w_level_nxt      = r_level;
    w_lives_nxt      = r_lives;
    w_score_nxt      = r_score;
    w_base_nxt       = r_base;
    w_cnt_nxt        = r_cnt;
    w_level_load_nxt = 1'b0;
    w_respawn_nxt    = 1'b0;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start_pulse) begin
          w_level_nxt      = '0;
          w_lives_nxt      = LIVES_INIT;
          w_score_nxt      = '0;
          w_base_nxt       = '0;
          w_cnt_nxt        = INTRO_LOAD;
          w_level_load_nxt = 1'b1;
        end
      end
      S_INTRO, S_RESPAWN: begin
        if (!w_cnt_done) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_PLAY: begin
        w_score_nxt = w_sum_sat;
        if (w_clear) begin
          w_base_nxt = w_sum_sat;
        end else if (bus.tank_destroyed) begin
          w_lives_nxt = w_lives_dec;
          if (w_lives_dec != 4'd0) begin
            w_respawn_nxt = 1'b1;
            w_cnt_nxt     = RESPAWN_LOAD;
          end
        end
      end
      S_LVL_DONE: begin
        if (!w_last_level) begin
          w_level_nxt      = r_level + LVL_W'(1);
          w_level_load_nxt = 1'b1;
          w_cnt_nxt        = INTRO_LOAD;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and pulse registers, so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level      <= '0;
      r_lives      <= LIVES_INIT;
      r_score      <= '0;
      r_base       <= '0;
      r_cnt        <= '0;
      r_level_load <= 1'b0;
      r_respawn    <= 1'b0;
    end else begin
      r_level      <= w_level_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_base       <= w_base_nxt;
      r_cnt        <= w_cnt_nxt;
      r_level_load <= w_level_load_nxt;
      r_respawn    <= w_respawn_nxt;
    end
  end

  assign bus.state      = r_state;
  assign bus.level      = r_level;
  assign bus.lives_left = r_lives;
  assign bus.score      = r_score;
  assign bus.level_load = r_level_load;
  assign bus.respawn    = r_respawn;
  assign bus.playing    = r_state[2];
  assign bus.win        = r_state[5];
  assign bus.lose       = r_state[6];

endmodule
